// File: rtl/cgra_stream_pkg.sv
// Shared types for the CGRA edge stream source: FSM states and FIFO occupancy width.
package cgra_stream_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   // Occupancy counters must represent 0..depth inclusive.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through buffer between memory read data and the array stream.
// Registered write only: a pushed word becomes visible at the head the following cycle.
module stream_fifo
   import cgra_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    pop,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = fifo_cnt_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cgra_stream_source.sv
// Strided memory reader that feeds one CGRA boundary input as a valid/ready stream.
// Requests are credit-limited so every in-flight read always has a FIFO slot waiting.
module cgra_stream_source
   import cgra_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] stride,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_v,
   input  logic                  dout_r
);

   localparam int CW = fifo_cnt_w(FIFO_DEPTH);

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] cfg_stride;
   logic [LEN_WIDTH-1:0]  cfg_len;
   logic [LEN_WIDTH-1:0]  issued;
   logic [CW-1:0]         outstanding;
   logic [CW-1:0]         fifo_count;
   logic [CW:0]           credit_used;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  gnt_fire;
   logic                  pop;
   logic                  accept_start;
   logic                  drained;

   assign credit_used  = {1'b0, fifo_count} + {1'b0, outstanding};
   assign mem_req      = (state == RUN) && (issued < cfg_len) && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign gnt_fire     = mem_req & mem_gnt;
   assign mem_addr     = addr;
   assign busy         = (state != IDLE);
   assign dout_v       = ~fifo_empty;
   assign pop          = dout_v & dout_r;
   assign accept_start = (state == IDLE) && start;
   assign drained      = (outstanding == '0) && fifo_empty;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start && length != '0) state_nx = RUN;
         RUN:     if (gnt_fire && (issued + LEN_WIDTH'(1) == cfg_len)) state_nx = DRAIN;
         DRAIN:   if (drained) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr        <= '0;
         cfg_stride  <= '0;
         cfg_len     <= '0;
         issued      <= '0;
         outstanding <= '0;
         done        <= 1'b0;
      end else begin
         state <= state_nx;
         // A zero-length start completes immediately without touching memory.
         done  <= (accept_start && length == '0) || (state == DRAIN && drained);
         if (accept_start && length != '0) begin
            addr       <= base_addr;
            cfg_stride <= stride;
            cfg_len    <= length;
            issued     <= '0;
         end else if (gnt_fire) begin
            addr   <= addr + cfg_stride;
            issued <= issued + LEN_WIDTH'(1);
         end
         case ({gnt_fire, mem_rvalid})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: ;
         endcase
      end
   end

   stream_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (mem_rvalid),
      .wdata (mem_rdata),
      .pop   (pop),
      .rdata (dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_cgra_stream_source.sv
// Directed bench for cgra_stream_source: table of strided streams plus hand-written stall/reset sequences.
module tb_cgra_stream_source;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr, stride;
   logic [15:0] length;
   logic        busy, done, mem_req, mem_gnt, mem_rvalid, dout_v, dout_r;
   logic [31:0] mem_addr, mem_rdata, dout;

   int checks = 0;
   int errors = 0;
   int lat    = 1;
   int done_cnt = 0;
   logic [31:0] got_addr [$];
   logic [31:0] got_data [$];

   always #5 clk = ~clk;

   cgra_stream_source dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .stride(stride),
      .length(length), .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .dout(dout), .dout_v(dout_v), .dout_r(dout_r)
   );

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Memory model: read data returns lat cycles after its grant, in order.
   logic [3:0]  rv_pipe;
   logic [31:0] rd_pipe [4];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rv_pipe <= '0;
         for (int i = 0; i < 4; i++) rd_pipe[i] <= '0;
      end else begin
         rv_pipe    <= {rv_pipe[2:0], mem_req & mem_gnt};
         rd_pipe[0] <= mem_f(mem_addr);
         for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end
   assign mem_rvalid = rv_pipe[lat-1];
   assign mem_rdata  = rd_pipe[lat-1];

   // Monitor: records transfers and checks hold-while-stalled on both interfaces.
   logic        p_req = 0, p_gnt = 0, p_v = 0, p_r = 0;
   logic [31:0] p_addr = 0, p_dout = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         p_req = 0; p_v = 0;
      end else begin
         if (p_req && !p_gnt) begin
            check("req_hold", {31'b0, mem_req}, 32'd1);
            check("addr_hold", mem_addr, p_addr);
         end
         if (p_v && !p_r) begin
            check("dout_v_hold", {31'b0, dout_v}, 32'd1);
            check("dout_hold", dout, p_dout);
         end
         if (mem_req && mem_gnt) got_addr.push_back(mem_addr);
         if (dout_v && dout_r) got_data.push_back(dout);
         if (done) done_cnt++;
         p_req = mem_req; p_gnt = mem_gnt; p_addr = mem_addr;
         p_v = dout_v; p_r = dout_r; p_dout = dout;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},   {31'b0, busy},    32'd0);
      check({tag, "_done"},   {31'b0, done},    32'd0);
      check({tag, "_req"},    {31'b0, mem_req}, 32'd0);
      check({tag, "_addr"},   mem_addr,         32'd0);
      check({tag, "_dout_v"}, {31'b0, dout_v},  32'd0);
      check({tag, "_dout"},   dout,             32'd0);
   endtask

   // Pulses start; returns #1 into the first cycle after start was sampled.
   task automatic kick(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
      got_addr.delete(); got_data.delete(); done_cnt = 0;
      @(posedge clk); #1;
      start = 1; base_addr = b; stride = s; length = l;
      @(posedge clk); #1;
      start = 0; base_addr = 32'hBAD0_0000; stride = 32'h0; length = 16'hFFFF;
      if (l != 0) begin
         check("busy_after_start", {31'b0, busy}, 32'd1);
         check("first_req", {31'b0, mem_req}, 32'd1);
         check("first_addr", mem_addr, b);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge clk);
      if (done_cnt == 0) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=0 expected=1");
      end
      repeat (3) @(negedge clk);
      check("done_pulses", done_cnt, 32'd1);
      check("busy_after_done", {31'b0, busy}, 32'd0);
      check("dout_v_after_done", {31'b0, dout_v}, 32'd0);
   endtask

   task automatic verify_stream(input logic [31:0] b, input logic [31:0] s, input int l);
      check("n_grants", got_addr.size(), l);
      check("n_words", got_data.size(), l);
      for (int i = 0; i < l && i < got_addr.size(); i++) check("addr", got_addr[i], b + s * i);
      for (int i = 0; i < l && i < got_data.size(); i++) check("data", got_data[i], mem_f(b + s * i));
   endtask

   typedef struct {
      logic [31:0] base;
      logic [31:0] stride;
      logic [15:0] len;
      logic [31:0] last_addr;
   } vec_t;
   vec_t vecs [4];

   initial begin
      vecs[0] = '{32'h0000_0100, 32'h0000_0004, 16'd3, 32'h0000_0108};
      vecs[1] = '{32'h0000_0004, 32'hFFFF_FFFC, 16'd3, 32'hFFFF_FFFC};
      vecs[2] = '{32'h0000_1000, 32'h0000_0010, 16'd5, 32'h0000_1040};
      vecs[3] = '{32'hFFFF_FFF8, 32'h0000_0008, 16'd2, 32'h0000_0000};

      rst_n = 0; start = 0; base_addr = 0; stride = 0; length = 0;
      mem_gnt = 1; dout_r = 1;
      #12;
      check_reset_outputs("reset");
      @(posedge clk); #1 rst_n = 1;

      // Table: free-flowing streams, including address wrap in both directions.
      for (int v = 0; v < 4; v++) begin
         kick(vecs[v].base, vecs[v].stride, vecs[v].len);
         wait_done();
         verify_stream(vecs[v].base, vecs[v].stride, vecs[v].len);
         if (got_addr.size() == vecs[v].len)
            check("last_addr", got_addr[vecs[v].len-1], vecs[v].last_addr);
      end

      // Sink stalled: credit limit caps grants at FIFO depth, each pop frees one.
      dout_r = 0;
      kick(32'h300, 32'h8, 16'd8);
      repeat (12) @(posedge clk); #1;
      check("stall_grants", got_addr.size(), 32'd4);
      check("stall_req", {31'b0, mem_req}, 32'd0);
      check("stall_dout_v", {31'b0, dout_v}, 32'd1);
      check("stall_dout", dout, mem_f(32'h300));
      start = 1; base_addr = 32'h9000; length = 16'd2;
      @(posedge clk); #1 start = 0;
      for (int k = 0; k < 4; k++) begin
         dout_r = 1;
         @(posedge clk); #1 dout_r = 0;
         repeat (5) @(posedge clk); #1;
         check("pulse_grants", got_addr.size(), 32'd5 + k);
      end
      dout_r = 1;
      wait_done();
      verify_stream(32'h300, 32'h8, 8);

      // Grant withheld for three cycles on the second request.
      kick(32'h100, 32'h4, 16'd3);
      @(posedge clk); #1 mem_gnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("gnt_wait_req", {31'b0, mem_req}, 32'd1);
         check("gnt_wait_addr", mem_addr, 32'h104);
      end
      @(posedge clk); #1 mem_gnt = 1;
      wait_done();
      verify_stream(32'h100, 32'h4, 3);

      // Zero length: done the very next cycle, no memory traffic.
      kick(32'h500, 32'h4, 16'd0);
      check("len0_done", {31'b0, done}, 32'd1);
      check("len0_busy", {31'b0, busy}, 32'd0);
      check("len0_req", {31'b0, mem_req}, 32'd0);
      @(posedge clk); #1;
      check("len0_done_drop", {31'b0, done}, 32'd0);
      check("len0_grants", got_addr.size(), 32'd0);

      // Reset with two reads in flight, then a clean follow-up run.
      lat = 3;
      kick(32'h700, 32'h4, 16'd8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_busy", {31'b0, busy}, 32'd1);
      rst_n = 0;
      #1;
      check_reset_outputs("midrst");
      lat = 1;
      @(posedge clk); #1 rst_n = 1;
      kick(32'h200, 32'h4, 16'd2);
      wait_done();
      verify_stream(32'h200, 32'h4, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
